// File: rtl/fetch_sequencer.sv
// Run-control and redirect arbiter in front of the PC register: sequences IDLE/RUN/STEP/HALTED
// and picks halt, branch, jump or stall each cycle, with stall/redirect performance counters.
module fetch_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int STEP_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic [STEP_W-1:0]    step_count,
    input  logic                 stop_req,
    input  logic                 halt_req,
    input  logic                 stall_req,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic                 jmp_valid,
    input  logic [WORD_SIZE-1:0] jmp_target,
    output logic                 pc_halt,
    output logic                 pc_bj,
    output logic [WORD_SIZE-1:0] pc_in,
    output logic                 flush,
    output logic [1:0]           state_o,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          redirect_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [STEP_W-1:0] step_left;
    logic [STEP_W-1:0] step_left_nx;
    logic              active;

    assign active  = (state == S_RUN) || (state == S_STEP);
    assign flush   = pc_bj;
    assign state_o = state;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pc_halt      = 1'b1;
        pc_bj        = 1'b0;
        pc_in        = '0;
        state_nx     = state;
        step_left_nx = step_left;

        // While rst is high the PC is held and any redirect is dropped.
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (run_req) begin
                        state_nx = S_RUN;
                    end else if (step_req && step_count != '0) begin
                        state_nx     = S_STEP;
                        step_left_nx = step_count;
                    end
                end
                S_RUN, S_STEP: begin
                    if (halt_req) begin
                        state_nx = S_HALTED;
                    end else if (stop_req) begin
                        state_nx = S_IDLE;
                    end else if (br_taken) begin
                        pc_halt = 1'b0;
                        pc_bj   = 1'b1;
                        pc_in   = br_target;
                    end else if (jmp_valid) begin
                        pc_halt = 1'b0;
                        pc_bj   = 1'b1;
                        pc_in   = jmp_target;
                    end else if (!stall_req) begin
                        pc_halt = 1'b0;
                    end

                    // Any cycle that moves the PC (increment or redirect) spends one step.
                    if (state == S_STEP && !pc_halt) begin
                        step_left_nx = step_left - 1'b1;
                        if (step_left == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                            state_nx = S_IDLE;
                        end
                    end
                end
                default: ;  // HALTED: sticky until reset
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state          <= S_IDLE;
            step_left      <= '0;
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            state     <= state_nx;
            step_left <= step_left_nx;
            if (active && pc_halt) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (active && pc_bj) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end

endmodule
